decode_stage: RTL

- Registered RV32 decode pipeline stage between the fetch buffer and the register-read/execute stage.
- Splits each instruction word into register addresses, function fields and the CSR address.
- Also generates the fully sign-extended immediate for every base format, classifies the format and flags illegal encodings.
- Valid/ready handshake on both sides, an optional 1-entry skid buffer for full throughput under backpressure, and a synchronous flush for branch redirects.

---
 rtl/decode_stage.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32 decode pipeline stage: splits the instruction word into fields, builds the sign-extended
// immediate, classifies the format and holds the decoded bundle behind a valid/ready handshake.
module decode_stage #(
  parameter int XLEN    = 32,
  parameter int PC_W    = 32,
  parameter bit SKID_EN = 1'b1,
  parameter bit CSR_EN  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [6:0]      opcode,
  output logic [4:0]      rda,
  output logic [2:0]      funct3,
  output logic [4:0]      r1a,
  output logic [4:0]      r2a,
  output logic            funct7_1bit,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      inst_type,
  output logic            illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rda;
    logic [2:0]      funct3;
    logic [4:0]      r1a;
    logic [4:0]      r2a;
    logic            funct7_1bit;
    logic [11:0]     csr_addr;
    logic [XLEN-1:0] imm;
    logic [2:0]      inst_type;
    logic            illegal;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_e;

  localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3;
  localparam logic [2:0] T_U = 3'd4, T_J = 3'd5, T_ILL = 3'd7;

  bundle_t         dec;
  logic [XLEN-1:0] sext;

  // Handshake: a transfer happens on a side only in a cycle where both valid and ready are high;
  // flush/rst override any transfer in the same cycle.
  always_comb begin
    sext            = {XLEN{inst[31]}};
    dec             = '0;
    dec.pc          = in_pc;
    dec.opcode      = inst[6:0];
    dec.rda         = inst[11:7];
    dec.funct3      = inst[14:12];
    dec.r1a         = inst[19:15];
    dec.r2a         = inst[24:20];
    dec.funct7_1bit = inst[30];
    dec.csr_addr    = inst[31:20];
    dec.imm         = '0;
    dec.inst_type   = T_ILL;
    dec.illegal     = 1'b1;
    if (inst[1:0] == 2'b11) begin
      case (inst[6:2])
        5'b01100: begin
          dec.inst_type = T_R;
          dec.illegal   = 1'b0;
        end
        5'b00000, 5'b00100, 5'b11001: begin
          dec.imm       = sext;
          dec.imm[11:0] = inst[31:20];
          dec.inst_type = T_I;
          dec.illegal   = 1'b0;
        end
        5'b11100: begin
          if (CSR_EN) begin
            dec.imm       = sext;
            dec.imm[11:0] = inst[31:20];
            dec.inst_type = T_I;
            dec.illegal   = 1'b0;
          end
        end
        5'b01000: begin
          dec.imm       = sext;
          dec.imm[11:0] = {inst[31:25], inst[11:7]};
          dec.inst_type = T_S;
          dec.illegal   = 1'b0;
        end
        5'b11000: begin
          dec.imm       = sext;
          dec.imm[12:0] = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
          dec.inst_type = T_B;
          dec.illegal   = 1'b0;
        end
        5'b01101, 5'b00101: begin
          dec.imm       = sext;
          dec.imm[31:0] = {inst[31:12], 12'b0};
          dec.inst_type = T_U;
          dec.illegal   = 1'b0;
        end
        5'b11011: begin
          dec.imm       = sext;
          dec.imm[20:0] = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
          dec.inst_type = T_J;
          dec.illegal   = 1'b0;
        end
        default: ;
      endcase
    end
  end

  state_e  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    in_ready_q, in_ready_d;
  logic    in_fire, out_fire;

  assign in_ready = SKID_EN ? in_ready_q : (!out_valid_q | out_ready);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  // Without the skid buffer in_ready already implies out_fire in FULL, so SKID is unreachable.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          main_d  = dec;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (in_fire && out_fire) begin
          main_d = dec;
        end else if (in_fire) begin
          skid_d  = dec;
          state_d = ST_SKID;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (out_fire) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end
    out_valid_d = (state_d != ST_EMPTY);
    in_ready_d  = (state_d != ST_SKID);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = main_q.pc;
  assign opcode      = main_q.opcode;
  assign rda         = main_q.rda;
  assign funct3      = main_q.funct3;
  assign r1a         = main_q.r1a;
  assign r2a         = main_q.r2a;
  assign funct7_1bit = main_q.funct7_1bit;
  assign csr_addr    = main_q.csr_addr;
  assign imm         = main_q.imm;
  assign inst_type   = main_q.inst_type;
  assign illegal     = main_q.illegal;

endmodule
